// File: rtl/plic_gateway.sv
// External interrupt gateway: per-source level/edge capture FSMs, enable masking,
// lowest-ID-wins arbitration and a single-claim handshake towards the trap unit.
module plic_gateway #(
  parameter int unsigned SRC_NUM = 31,
  parameter int unsigned IDW     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SRC_NUM-1:0] src_i,
  output logic               ex_trap_valid_o,
  output logic [IDW-1:0]     ex_trap_id_o,
  input  logic               ex_trap_ready_i,
  input  logic               ex_trap_cplet_i,
  input  logic [IDW-1:0]     ex_trap_cplet_id_i,
  input  logic               reg_we_i,
  input  logic [3:0]         reg_addr_i,
  input  logic [31:0]        reg_wdata_i,
  output logic [31:0]        reg_rdata_o
);

  typedef enum logic [1:0] {StIdle, StPending, StClaimed} gw_state_e;

  gw_state_e          state_q [SRC_NUM];
  gw_state_e          state_d [SRC_NUM];
  logic [SRC_NUM-1:0] again_q, again_d;
  logic [SRC_NUM-1:0] src_q;
  logic [SRC_NUM-1:0] enable_q, edge_q;
  logic               ready_q, hold_q, hold_d;
  logic               valid_q, valid_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [SRC_NUM-1:0] rise, pending_vec, claimed_vec, cand;
  logic               claim, busy;
  logic [IDW-1:0]     claimed_id;

  logic unused_bits;
  assign unused_bits = ^{reg_addr_i[1:0], reg_wdata_i};

  function automatic logic [IDW-1:0] lowest_idx(input logic [SRC_NUM-1:0] v);
    lowest_idx = '0;
    for (int i = int'(SRC_NUM) - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDW'(i);
    end
  endfunction

  assign rise  = src_i & ~src_q;
  assign claim = ex_trap_ready_i & ~ready_q & valid_q;

  always_comb begin
    pending_vec = '0;
    claimed_vec = '0;
    for (int i = 0; i < int'(SRC_NUM); i++) begin
      pending_vec[i] = (state_q[i] == StPending);
      claimed_vec[i] = (state_q[i] == StClaimed);
    end
  end

  assign cand       = pending_vec & enable_q;
  assign busy       = |claimed_vec;
  assign claimed_id = lowest_idx(claimed_vec);

  always_comb begin
    again_d = again_q;
    for (int i = 0; i < int'(SRC_NUM); i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        StIdle: begin
          if (edge_q[i] ? rise[i] : src_i[i]) state_d[i] = StPending;
        end
        StPending: begin
          if (claim && (id_q == IDW'(i))) state_d[i] = StClaimed;
        end
        StClaimed: begin
          if (edge_q[i] && rise[i]) again_d[i] = 1'b1;
          if (ex_trap_cplet_i && (ex_trap_cplet_id_i == IDW'(i))) begin
            // An edge seen during service re-pends immediately on completion.
            state_d[i] = (again_q[i] || (edge_q[i] && rise[i])) ? StPending : StIdle;
            again_d[i] = 1'b0;
          end
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  // Hold the claimed ID on the outputs for as long as ready stays high.
  always_comb begin
    hold_d  = claim | (hold_q & ex_trap_ready_i);
    valid_d = valid_q;
    id_d    = id_q;
    if (!hold_d) begin
      valid_d = (|cand) & ~busy;
      id_d    = valid_d ? lowest_idx(cand) : '0;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (reg_addr_i[3:2])
      2'd0: rdata_d[SRC_NUM-1:0] = enable_q;
      2'd1: rdata_d[SRC_NUM-1:0] = edge_q;
      2'd2: rdata_d[SRC_NUM-1:0] = pending_vec;
      default: begin
        rdata_d[31]      = busy;
        rdata_d[IDW-1:0] = busy ? claimed_id : '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(SRC_NUM); i++) state_q[i] <= StIdle;
      again_q  <= '0;
      src_q    <= '0;
      enable_q <= '0;
      edge_q   <= '0;
      ready_q  <= 1'b0;
      hold_q   <= 1'b0;
      valid_q  <= 1'b0;
      id_q     <= '0;
      rdata_q  <= '0;
    end else begin
      for (int i = 0; i < int'(SRC_NUM); i++) state_q[i] <= state_d[i];
      again_q <= again_d;
      src_q   <= src_i;
      ready_q <= ex_trap_ready_i;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      rdata_q <= rdata_d;
      if (reg_we_i && (reg_addr_i[3:2] == 2'd0)) enable_q <= reg_wdata_i[SRC_NUM-1:0];
      if (reg_we_i && (reg_addr_i[3:2] == 2'd1)) edge_q   <= reg_wdata_i[SRC_NUM-1:0];
    end
  end

  assign ex_trap_valid_o = valid_q;
  assign ex_trap_id_o    = id_q;
  assign reg_rdata_o     = rdata_q;

endmodule

// File: tb/tb_plic_gateway.sv
// Directed bench for plic_gateway; expectations queued at stimulus, checked on output.
module tb_plic_gateway;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [30:0] src = '0;
  logic        valid;
  logic [4:0]  id;
  logic        ready = 1'b0;
  logic        cplet = 1'b0;
  logic [4:0]  cplet_id = '0;
  logic        we = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  plic_gateway #(.SRC_NUM(31), .IDW(5)) dut (
    .clk                (clk),
    .rst                (rst),
    .src_i              (src),
    .ex_trap_valid_o    (valid),
    .ex_trap_id_o       (id),
    .ex_trap_ready_i    (ready),
    .ex_trap_cplet_i    (cplet),
    .ex_trap_cplet_id_i (cplet_id),
    .reg_we_i           (we),
    .reg_addr_i         (addr),
    .reg_wdata_i        (wdata),
    .reg_rdata_o        (rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty obs=%h exp=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s obs=%h exp=%h", t, obs, e);
      end
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] e);
    addr = a;
    push(tag, e);
    step();
    pop(rdata);
  endtask

  task automatic out_chk(input string tag, input logic v, input logic [4:0] i);
    push({tag, "_valid"}, {31'd0, v});
    push({tag, "_id"}, {27'd0, i});
    pop({31'd0, valid});
    pop({27'd0, id});
  endtask

  initial begin
    // Reset state
    #2;
    out_chk("reset", 1'b0, 5'd0);
    push("reset_rdata", 32'h0);
    pop(rdata);
    step();
    rst = 1'b0;
    step();

    // Upper enable bit beyond SRC_NUM is not writable
    wr(4'h0, 32'hFFFF_FFFF);
    rd("enable_mask", 4'h0, 32'h7FFF_FFFF);

    // Level source 5 offered two cycles after rise
    wr(4'h0, 32'h0000_0020);
    src[5] = 1'b1;
    step();
    out_chk("lvl5_k", 1'b0, 5'd0);
    step();
    out_chk("lvl5_k1", 1'b1, 5'd5);
    rd("pending5", 4'h8, 32'h0000_0020);
    src[5] = 1'b0;
    ready = 1'b1; step(); ready = 1'b0; step();
    cplet = 1'b1; cplet_id = 5'd5; step(); cplet = 1'b0; step();

    // Sources 3 and 7 together: lowest wins, held during ready
    wr(4'h0, 32'h0000_0088);
    src[3] = 1'b1; src[7] = 1'b1;
    step(); step();
    out_chk("prio3", 1'b1, 5'd3);
    src[3] = 1'b0; src[7] = 1'b0;
    addr = 4'hC;
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      out_chk("hold3", 1'b1, 5'd3);
    end
    push("status3", 32'h8000_0003);
    pop(rdata);
    ready = 1'b0;
    step();
    out_chk("after_ready", 1'b0, 5'd0);
    cplet = 1'b1; cplet_id = 5'd3;
    step();
    cplet = 1'b0;
    out_chk("cplet3_c1", 1'b0, 5'd0);
    step();
    out_chk("cplet3_c2", 1'b1, 5'd7);
    ready = 1'b1; step(); ready = 1'b0; step();
    cplet = 1'b1; cplet_id = 5'd7; step(); cplet = 1'b0; step();
    rd("status_idle", 4'hC, 32'h0);

    // Edge source 2 with a second pulse during service
    wr(4'h4, 32'h0000_0004);
    wr(4'h0, 32'h0000_0004);
    src[2] = 1'b1; step(); src[2] = 1'b0; step();
    out_chk("edge2", 1'b1, 5'd2);
    ready = 1'b1; step(); ready = 1'b0; step();
    out_chk("edge2_claimed", 1'b0, 5'd0);
    src[2] = 1'b1; step(); src[2] = 1'b0; step();
    cplet = 1'b1; cplet_id = 5'd2; step(); cplet = 1'b0; step();
    out_chk("edge2_again", 1'b1, 5'd2);
    ready = 1'b1; step(); ready = 1'b0; step();
    cplet = 1'b1; cplet_id = 5'd2; step(); cplet = 1'b0; step(); step();
    out_chk("edge2_noagain", 1'b0, 5'd0);
    rd("pending_none", 4'h8, 32'h0);

    // Complete with wrong ID is ignored; masked pending source
    wr(4'h4, 32'h0);
    wr(4'h0, 32'h0000_0010);
    src[4] = 1'b1; step(); step();
    out_chk("lvl4", 1'b1, 5'd4);
    src[4] = 1'b0;
    ready = 1'b1; step(); ready = 1'b0; step();
    cplet = 1'b1; cplet_id = 5'd9; step(); cplet = 1'b0; step(); step();
    out_chk("cplet9", 1'b0, 5'd0);
    rd("status4", 4'hC, 32'h8000_0004);
    src[1] = 1'b1; step(); step();
    src[1] = 1'b0;
    rd("pending_masked", 4'h8, 32'h0000_0002);
    out_chk("masked1", 1'b0, 5'd0);

    // Release 4, enable 1, then reset during claim hold
    cplet = 1'b1; cplet_id = 5'd4; step(); cplet = 1'b0;
    wr(4'h0, 32'h0000_0002);
    step(); step();
    out_chk("src1", 1'b1, 5'd1);
    ready = 1'b1; step(); step();
    out_chk("hold1", 1'b1, 5'd1);
    #1 rst = 1'b1;
    #1;
    out_chk("rst_mid", 1'b0, 5'd0);
    push("rst_mid_rdata", 32'h0);
    pop(rdata);
    ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    rd("rst_enable", 4'h0, 32'h0);
    rd("rst_status", 4'hC, 32'h0);
    rd("rst_pending", 4'h8, 32'h0);
    out_chk("rst_out", 1'b0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
